// File: rtl/conv_read_sequencer.sv
// Steps window j / tap k across input and filter memories into the MAC; first y_valid M+2 cycles after start.
// Each output holds in OUT until y_ready, and no strobe or address moves while it waits.
module conv_read_sequencer #(
  parameter int N    = 43,
  parameter int M    = 16,
  parameter int XA_W = 6,
  parameter int FA_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            x_full,
  input  logic            f_full,
  input  logic            y_ready,
  output logic            en_ext_ctrl,
  output logic            ext_load_addr,
  output logic [XA_W-1:0] ext_load_addr_val,
  output logic            ext_incr_addr,
  output logic [FA_W-1:0] f_addr,
  output logic            mac_clear,
  output logic            mac_en,
  output logic            y_valid,
  output logic            done
);

  localparam logic [XA_W-1:0] J_LAST = XA_W'(N - M);
  localparam logic [FA_W-1:0] K_LAST = FA_W'(M - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ACC, DRAIN, OUT, DONE} state_t;

  state_t          state, state_nxt;
  logic [XA_W-1:0] j, j_nxt;
  logic [FA_W-1:0] k, k_nxt;
  logic            mac_en_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      j        <= '0;
      k        <= '0;
      mac_en_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      j        <= j_nxt;
      k        <= k_nxt;
      // one-cycle lag lines the accumulate up with the memory read latency
      mac_en_q <= (state == ACC);
    end
  end

  always_comb begin
    state_nxt     = state;
    j_nxt         = j;
    k_nxt         = k;
    en_ext_ctrl   = 1'b0;
    ext_load_addr = 1'b0;
    ext_incr_addr = 1'b0;
    mac_clear     = 1'b0;
    y_valid       = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        j_nxt = '0;
        k_nxt = '0;
        if (x_full && f_full) state_nxt = LOAD;
      end
      LOAD: begin
        en_ext_ctrl   = 1'b1;
        ext_load_addr = 1'b1;
        mac_clear     = 1'b1;
        k_nxt         = '0;
        state_nxt     = ACC;
      end
      ACC: begin
        en_ext_ctrl = 1'b1;
        if (k == K_LAST) begin
          state_nxt = DRAIN;
        end else begin
          ext_incr_addr = 1'b1;
          k_nxt         = k + FA_W'(1);
        end
      end
      DRAIN: begin
        en_ext_ctrl = 1'b1;
        state_nxt   = OUT;
      end
      OUT: begin
        en_ext_ctrl = 1'b1;
        y_valid     = 1'b1;
        if (y_ready) begin
          k_nxt = '0;
          if (j == J_LAST) begin
            state_nxt = DONE;
          end else begin
            j_nxt     = j + XA_W'(1);
            state_nxt = LOAD;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        j_nxt     = '0;
        k_nxt     = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ext_load_addr_val = j;
  assign f_addr            = k;
  assign mac_en            = mac_en_q;

endmodule
